// File: rtl/crc_rx_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : crc_rx_checker_if
// Description : Bit-stream and result bundle between the USB receive
//               front end and the CRC checker.
// Revision    : 1.0
// ============================================================================
interface crc_rx_checker_if #(
    parameter int MAX_BITS = 8256,
    parameter int CNT_W    = 14
);
    logic                bit_valid;
    logic                in_bit;
    logic                eop;
    logic                abort;
    logic                busy;
    logic                done;
    logic                crc_ok;
    logic                len_err;
    logic [CNT_W-1:0]    payload_len;
    logic [MAX_BITS-1:0] payload;

    modport master (
        output bit_valid, in_bit, eop, abort,
        input  busy, done, crc_ok, len_err, payload_len, payload
    );

    modport slave (
        input  bit_valid, in_bit, eop, abort,
        output busy, done, crc_ok, len_err, payload_len, payload
    );
endinterface
`default_nettype wire

// File: rtl/crc_rx_checker.sv
`default_nettype none
// ============================================================================
// Module      : crc_rx_checker
// Description : Serial CRC-N checker with indexed payload capture for the
//               USB receive path (CRC16 data / CRC5 token instances).
// Revision    : 1.0
// ============================================================================
module crc_rx_checker #(
    parameter int               CRC_W    = 16,
    parameter logic [CRC_W-1:0] POLY     = 16'h8005,
    parameter logic [CRC_W-1:0] RESIDUE  = 16'h800D,
    parameter int               MAX_BITS = 8256,
    parameter int               CNT_W    = 14
) (
    input  wire logic       clock,
    input  wire logic       reset,
    crc_rx_checker_if.slave rx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam int               c_IDX_W = $clog2(MAX_BITS);
    localparam logic [CNT_W-1:0] c_MAX   = CNT_W'(MAX_BITS);
    localparam logic [CNT_W-1:0] c_OVF   = CNT_W'(MAX_BITS + 1);
    localparam logic [CNT_W-1:0] c_CRC_W = CNT_W'(CRC_W);
    localparam logic [CRC_W-1:0] c_ONES  = '1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CRC_W-1:0]    r_lfsr;
    logic [CRC_W-1:0]    w_lfsr_nxt;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [CNT_W-1:0]    w_bit_cnt_nxt;
    logic [MAX_BITS-1:0] r_payload;
    logic                r_done;
    logic                r_crc_ok;
    logic                r_len_err;
    logic [CNT_W-1:0]    r_payload_len;
    logic                w_accept;
    logic                w_fb;
    logic                w_len_err;
    logic                w_check_fire;

    assign w_fb         = rx.in_bit ^ r_lfsr[CRC_W-1];
    assign w_len_err    = (r_bit_cnt < c_CRC_W) || (r_bit_cnt > c_MAX);
    assign w_check_fire = (r_state == CHECK) && !rx.abort;

    always_comb begin
        w_state_nxt   = r_state;
        w_lfsr_nxt    = r_lfsr;
        w_bit_cnt_nxt = r_bit_cnt;
        w_accept      = 1'b0;
        case (r_state)
            IDLE, SHIFT: begin
                if (rx.bit_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SHIFT;
                end
                // A bit arriving with eop is absorbed before the check.
                if (rx.eop) begin
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                w_state_nxt   = IDLE;
                w_lfsr_nxt    = c_ONES;
                w_bit_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (w_accept) begin
            w_lfsr_nxt = {r_lfsr[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
            if (r_bit_cnt != c_OVF) begin
                w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            end
        end
        if (rx.abort) begin
            w_accept      = 1'b0;
            w_state_nxt   = IDLE;
            w_lfsr_nxt    = c_ONES;
            w_bit_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_lfsr        <= c_ONES;
            r_bit_cnt     <= '0;
            r_done        <= 1'b0;
            r_crc_ok      <= 1'b0;
            r_len_err     <= 1'b0;
            r_payload_len <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lfsr    <= w_lfsr_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_done    <= w_check_fire;
            if (w_check_fire) begin
                r_len_err     <= w_len_err;
                r_crc_ok      <= !w_len_err && (r_lfsr == RESIDUE);
                r_payload_len <= w_len_err ? '0 : (r_bit_cnt - c_CRC_W);
            end
        end
    end

    // Capture buffer has no reset; stale bits above payload_len are harmless.
    always_ff @(posedge clock) begin
        if (w_accept && (r_bit_cnt < c_MAX)) begin
            r_payload[r_bit_cnt[c_IDX_W-1:0]] <= rx.in_bit;
        end
    end

    assign rx.busy        = (r_state != IDLE);
    assign rx.done        = r_done;
    assign rx.crc_ok      = r_crc_ok;
    assign rx.len_err     = r_len_err;
    assign rx.payload_len = r_payload_len;
    assign rx.payload     = r_payload;

endmodule
`default_nettype wire

// File: tb/tb_crc_rx_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc_rx_checker
// Description : Self-checking bench for crc_rx_checker (CRC16 and CRC5).
// Revision    : 1.0
// ============================================================================
module tb_crc_rx_checker;

    localparam int MAX16 = 8256;
    localparam int CNT16 = 14;
    localparam int MAX5  = 64;
    localparam int CNT5  = 7;

    typedef bit bitq_t[$];

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    crc_rx_checker_if #(.MAX_BITS(MAX16), .CNT_W(CNT16)) bus16 ();
    crc_rx_checker_if #(.MAX_BITS(MAX5),  .CNT_W(CNT5))  bus5 ();

    crc_rx_checker #(.CRC_W(16), .POLY(16'h8005), .RESIDUE(16'h800D),
                     .MAX_BITS(MAX16), .CNT_W(CNT16))
        dut16 (.clock(clock), .reset(reset), .rx(bus16.slave));

    crc_rx_checker #(.CRC_W(5), .POLY(5'h05), .RESIDUE(5'h0C),
                     .MAX_BITS(MAX5), .CNT_W(CNT5))
        dut5 (.clock(clock), .reset(reset), .rx(bus5.slave));

    int n_pass  = 0;
    int n_total = 0;
    int done16  = 0;
    int done5   = 0;

    bit obs_seen;
    int obs_lat;
    bit obs_ok;
    bit obs_err;
    int obs_plen;

    always @(posedge clock) begin
        if (bus16.done) done16 <= done16 + 1;
        if (bus5.done)  done5  <= done5 + 1;
    end

    // ---------------- reference model (reflected CRC, USB style) ----------
    function automatic int w_of(bit sel);   return sel ? 5 : 16;          endfunction
    function automatic int poly_of(bit sel); return sel ? 'h05 : 'h8005;  endfunction
    function automatic int res_of(bit sel);  return sel ? 'h0C : 'h800D;  endfunction
    function automatic int max_of(bit sel);  return sel ? MAX5 : MAX16;   endfunction

    function automatic int bitrev(int v, int w);
        int r = 0;
        for (int i = 0; i < w; i++) if (v[i]) r |= (1 << (w - 1 - i));
        return r;
    endfunction

    function automatic int crc_reg(bit sel, bitq_t q);
        int w  = w_of(sel);
        int pr = bitrev(poly_of(sel), w);
        int c  = (1 << w) - 1;
        foreach (q[i]) begin
            if (((c & 1) ^ int'(q[i])) != 0) c = (c >> 1) ^ pr;
            else                            c = c >> 1;
        end
        return c;
    endfunction

    function automatic bitq_t make_packet(bit sel, bitq_t pl);
        bitq_t pk = pl;
        int    w  = w_of(sel);
        int    c  = crc_reg(sel, pl) ^ ((1 << w) - 1);
        for (int i = 0; i < w; i++) pk.push_back(c[i]);
        return pk;
    endfunction

    function automatic bitq_t rand_bits(int n);
        bitq_t q;
        for (int i = 0; i < n; i++) q.push_back(1'($urandom));
        return q;
    endfunction

    function automatic bit pl_bit(bit sel, int i);
        return sel ? bus5.payload[i] : bus16.payload[i];
    endfunction

    // ---------------- stimulus helpers ------------------------------------
    task automatic drive(input bit sel, input bit v, input bit b, input bit e, input bit a);
        @(negedge clock);
        if (sel) begin
            bus5.bit_valid = v; bus5.in_bit = b; bus5.eop = e; bus5.abort = a;
        end else begin
            bus16.bit_valid = v; bus16.in_bit = b; bus16.eop = e; bus16.abort = a;
        end
    endtask

    task automatic send_bits(input bit sel, input bitq_t q, input int mode);
        int ones = 0;
        foreach (q[i]) begin
            if (mode == 2 && $urandom_range(0, 3) == 0) drive(sel, 1'b0, 1'($urandom), 1'b0, 1'b0);
            drive(sel, 1'b1, q[i], 1'b0, 1'b0);
            ones = q[i] ? ones + 1 : 0;
            if (mode == 1 && ones == 6) begin
                drive(sel, 1'b0, 1'b1, 1'b0, 1'b0);
                ones = 0;
            end
        end
    endtask

    task automatic run_packet(input bit sel, input bitq_t q, input int mode);
        send_bits(sel, q, mode);
        drive(sel, 1'b0, 1'b0, 1'b1, 1'b0);
        obs_seen = 1'b0;
        obs_lat  = 0;
        for (int i = 1; i <= 4; i++) begin
            drive(sel, 1'b0, 1'b0, 1'b0, 1'b0);
            if ((sel ? bus5.done : bus16.done) && !obs_seen) begin
                obs_seen = 1'b1;
                obs_lat  = i;
                obs_ok   = sel ? bus5.crc_ok  : bus16.crc_ok;
                obs_err  = sel ? bus5.len_err : bus16.len_err;
                obs_plen = sel ? int'(bus5.payload_len) : int'(bus16.payload_len);
            end
        end
    endtask

    // ---------------- tests -----------------------------------------------
    task automatic test_reset();
        @(negedge clock);
        #1;
        n_total++; if (bus16.busy !== 1'b0) $display("FAIL reset_busy16: got %b want 0", bus16.busy); else n_pass++;
        n_total++; if (bus16.done !== 1'b0) $display("FAIL reset_done16: got %b want 0", bus16.done); else n_pass++;
        n_total++; if (bus16.crc_ok !== 1'b0) $display("FAIL reset_ok16: got %b want 0", bus16.crc_ok); else n_pass++;
        n_total++; if (bus16.len_err !== 1'b0) $display("FAIL reset_err16: got %b want 0", bus16.len_err); else n_pass++;
        n_total++; if (bus16.payload_len !== '0) $display("FAIL reset_plen16: got %0d want 0", bus16.payload_len); else n_pass++;
        n_total++; if (bus5.busy !== 1'b0 || bus5.done !== 1'b0) $display("FAIL reset_bus5: got busy %b done %b want 0 0", bus5.busy, bus5.done); else n_pass++;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_zlp();
        bitq_t empty;
        bitq_t pk = make_packet(1'b0, empty);
        run_packet(1'b0, pk, 0);
        n_total++; if (!obs_seen) $display("FAIL zlp_done: got no done want done"); else n_pass++;
        n_total++; if (obs_lat !== 2) $display("FAIL zlp_latency: got %0d want 2", obs_lat); else n_pass++;
        n_total++; if (obs_ok !== 1'b1 || obs_err !== 1'b0) $display("FAIL zlp_result: got ok %b err %b want 1 0", obs_ok, obs_err); else n_pass++;
        n_total++; if (obs_plen !== 0) $display("FAIL zlp_plen: got %0d want 0", obs_plen); else n_pass++;
    endtask

    task automatic test_known(input int mode);
        bitq_t       pl;
        bitq_t       pk;
        logic [7:0]  by;
        logic [15:0] exp_crc;
        for (int k = 0; k < 4; k++) begin
            by = 8'(k);
            for (int j = 0; j < 8; j++) pl.push_back(by[j]);
        end
        pk = make_packet(1'b0, pl);
        for (int i = 0; i < 16; i++) exp_crc[i] = pk[32 + i];
        run_packet(1'b0, pk, mode);
        n_total++; if (!obs_seen || obs_ok !== 1'b1 || obs_err !== 1'b0) $display("FAIL known_ok(mode %0d): got seen %b ok %b err %b want 1 1 0", mode, obs_seen, obs_ok, obs_err); else n_pass++;
        n_total++; if (obs_plen !== 32) $display("FAIL known_plen(mode %0d): got %0d want 32", mode, obs_plen); else n_pass++;
        n_total++; if (bus16.payload[31:0] !== 32'h03020100) $display("FAIL known_payload(mode %0d): got %h want 03020100", mode, bus16.payload[31:0]); else n_pass++;
        n_total++; if (bus16.payload[47:32] !== exp_crc) $display("FAIL known_crcfield(mode %0d): got %h want %h", mode, bus16.payload[47:32], exp_crc); else n_pass++;
        if (mode == 0) begin
            pk[5] = ~pk[5];
            run_packet(1'b0, pk, 0);
            n_total++; if (!obs_seen || obs_ok !== 1'b0 || obs_err !== 1'b0) $display("FAIL known_flip: got seen %b ok %b err %b want 1 0 0", obs_seen, obs_ok, obs_err); else n_pass++;
        end
    endtask

    task automatic test_short();
        run_packet(1'b0, rand_bits(10), 0);
        n_total++; if (!obs_seen || obs_err !== 1'b1 || obs_ok !== 1'b0 || obs_plen !== 0) $display("FAIL short: got seen %b err %b ok %b plen %0d want 1 1 0 0", obs_seen, obs_err, obs_ok, obs_plen); else n_pass++;
    endtask

    task automatic test_overflow();
        bitq_t q = rand_bits(MAX16 + 1);
        int    bad = 0;
        run_packet(1'b0, q, 0);
        n_total++; if (!obs_seen || obs_err !== 1'b1 || obs_ok !== 1'b0 || obs_plen !== 0) $display("FAIL overflow: got seen %b err %b ok %b plen %0d want 1 1 0 0", obs_seen, obs_err, obs_ok, obs_plen); else n_pass++;
        for (int i = 0; i < MAX16; i++) if (bus16.payload[i] !== q[i]) bad++;
        n_total++; if (bad != 0) $display("FAIL overflow_buffer: got %0d wrong bits want 0", bad); else n_pass++;
    endtask

    task automatic test_abort();
        bitq_t empty;
        int    d0;
        @(negedge clock);
        d0 = done16;
        send_bits(1'b0, rand_bits(20), 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_total++; if (bus16.busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", bus16.busy); else n_pass++;
        run_packet(1'b0, make_packet(1'b0, empty), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_total++; if (done16 - d0 != 1) $display("FAIL abort_done_count: got %0d want 1", done16 - d0); else n_pass++;
        n_total++; if (obs_ok !== 1'b1 || obs_plen !== 0) $display("FAIL abort_zlp: got ok %b plen %0d want 1 0", obs_ok, obs_plen); else n_pass++;
    endtask

    task automatic test_abort_eop();
        int d0;
        @(negedge clock);
        d0 = done16;
        send_bits(1'b0, rand_bits(8), 0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_total++; if (done16 != d0) $display("FAIL abort_eop_done: got %0d pulses want 0", done16 - d0); else n_pass++;
        n_total++; if (bus16.busy !== 1'b0 || bus16.crc_ok !== 1'b1) $display("FAIL abort_eop_state: got busy %b ok %b want 0 1", bus16.busy, bus16.crc_ok); else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            bit    sel  = 1'($urandom);
            int    w    = w_of(sel);
            int    mx   = max_of(sel);
            bitq_t pk   = make_packet(sel, rand_bits(sel ? $urandom_range(0, 70) : $urandom_range(0, 120)));
            int    n;
            bit    e_err;
            bit    e_ok;
            int    e_plen;
            int    bad = 0;
            if (pk.size() > 0 && $urandom_range(0, 2) == 0) begin
                int p = $urandom_range(0, pk.size() - 1);
                pk[p] = ~pk[p];
            end
            if ($urandom_range(0, 4) == 0) pk = pk[0:$urandom_range(0, pk.size() - 1)];
            n      = pk.size();
            e_err  = (n < w) || (n > mx);
            e_ok   = !e_err && (crc_reg(sel, pk) == bitrev(res_of(sel), w));
            e_plen = e_err ? 0 : n - w;
            run_packet(sel, pk, $urandom_range(0, 2));
            n_total++; if (!obs_seen || obs_ok !== e_ok || obs_err !== e_err || obs_plen !== e_plen)
                $display("FAIL random_%0d(sel %0d n %0d): got seen %b ok %b err %b plen %0d want 1 %b %b %0d", it, sel, n, obs_seen, obs_ok, obs_err, obs_plen, e_ok, e_err, e_plen);
            else n_pass++;
            for (int i = 0; i < n && i < mx; i++) if (pl_bit(sel, i) !== pk[i]) bad++;
            n_total++; if (bad != 0) $display("FAIL random_buf_%0d: got %0d wrong bits want 0", it, bad); else n_pass++;
        end
    endtask

    task automatic test_crc5();
        bitq_t pk = make_packet(1'b1, rand_bits(11));
        run_packet(1'b1, pk, 0);
        n_total++; if (!obs_seen || obs_ok !== 1'b1 || obs_err !== 1'b0 || obs_plen !== 11) $display("FAIL crc5_token: got seen %b ok %b err %b plen %0d want 1 1 0 11", obs_seen, obs_ok, obs_err, obs_plen); else n_pass++;
        pk = make_packet(1'b1, rand_bits(MAX5 - 5));
        run_packet(1'b1, pk, 0);
        n_total++; if (!obs_seen || obs_ok !== 1'b1 || obs_err !== 1'b0 || obs_plen !== MAX5 - 5) $display("FAIL crc5_full: got seen %b ok %b err %b plen %0d want 1 1 0 %0d", obs_seen, obs_ok, obs_err, obs_plen, MAX5 - 5); else n_pass++;
        pk = make_packet(1'b1, rand_bits(MAX5 - 4));
        run_packet(1'b1, pk, 0);
        n_total++; if (!obs_seen || obs_ok !== 1'b0 || obs_err !== 1'b1 || obs_plen !== 0) $display("FAIL crc5_over: got seen %b ok %b err %b plen %0d want 1 0 1 0", obs_seen, obs_ok, obs_err, obs_plen); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int d0;
        send_bits(1'b1, rand_bits(6), 0);
        @(negedge clock);
        n_total++; if (bus5.busy !== 1'b1) $display("FAIL reset_mid_pre: got busy %b want 1", bus5.busy); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++; if (bus5.busy !== 1'b0 || bus5.done !== 1'b0 || bus5.crc_ok !== 1'b0) $display("FAIL reset_mid_async: got busy %b done %b ok %b want 0 0 0", bus5.busy, bus5.done, bus5.crc_ok); else n_pass++;
        #1 reset = 1'b0;
        d0 = done5;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        d0 = done5 - d0;
        // The eop after reset starts a fresh zero-bit packet: exactly one done, length error.
        n_total++; if (d0 != 1 || bus5.len_err !== 1'b1 || bus5.busy !== 1'b0) $display("FAIL reset_mid_after: got dones %0d err %b busy %b want 1 1 0", d0, bus5.len_err, bus5.busy); else n_pass++;
    endtask

    initial begin
        bus16.bit_valid = 1'b0; bus16.in_bit = 1'b0; bus16.eop = 1'b0; bus16.abort = 1'b0;
        bus5.bit_valid  = 1'b0; bus5.in_bit  = 1'b0; bus5.eop  = 1'b0; bus5.abort  = 1'b0;
        test_reset();
        test_zlp();
        test_known(0);
        test_known(1);
        test_short();
        test_overflow();
        test_abort();
        test_abort_eop();
        test_random();
        test_crc5();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
